// File: rtl/serial_pkg.sv
// Purpose: shared state encodings and line constants for the serial rx/tx pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } serial_state_t;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for asynchronous inputs, reset to RST_VAL.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
module sync_2ff #(
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/serial_rx.sv
// Purpose: UART-style receiver, start + DATA_BITS (LSB first) + stop; SERIAL_RX_PARITY_EN adds even parity.
// Latency: data_valid ~3 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after the start edge.
// Backpressure: none; each word is a one-cycle data_valid pulse and must be taken that cycle.
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 bit_end;
    serial_state_t        state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 parity_err_q, parity_err_d;
`endif

    sync_2ff #(.WIDTH(1), .RST_VAL(LINE_IDLE)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_in),
        .q     (rx_s)
    );

    assign bit_end = (cnt_q == CNT_END);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rx_s != LINE_IDLE) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                // Re-check at mid start bit; a short low pulse is a glitch.
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (rx_s == LINE_IDLE) state_d = IDLE;
                    else                   state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                // Leave at stop mid-bit so a back-to-back start bit is caught.
                if (bit_end) begin
                    cnt_d = '0;
                    if (rx_s == LINE_IDLE) begin
`ifdef SERIAL_RX_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            parity_err_d = 1'b1;
                        end else begin
                            data_out_d   = shift_q;
                            data_valid_d = 1'b1;
                        end
`else
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BREAK: begin
                if (rx_s == LINE_IDLE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef SERIAL_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx at CLKS_PER_BIT=4, DATA_BITS=8; parity scenarios under SERIAL_RX_PARITY_EN.
module tb_serial_rx;

    localparam int CPB = 4;
    localparam int DB  = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam int LAT = 3 + CPB / 2 + DB * CPB + CPB + CPB;
`else
    localparam int LAT = 3 + CPB / 2 + DB * CPB + CPB;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
`ifdef SERIAL_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vld_cnt, ferr_cnt, perr_cnt, both_cnt, vld_cyc;
    logic [7:0] capt [4];

    serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef SERIAL_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid) begin
                if (vld_cnt < 4) capt[vld_cnt] = data_out;
                vld_cyc = cyc;
                vld_cnt++;
            end
            if (frame_err) ferr_cnt++;
            if (data_valid && frame_err) both_cnt++;
`ifdef SERIAL_RX_PARITY_EN
            if (parity_err) perr_cnt++;
            if (parity_err && (data_valid || frame_err)) both_cnt++;
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        vld_cnt  = 0;
        ferr_cnt = 0;
        perr_cnt = 0;
        for (int i = 0; i < 4; i++) capt[i] = 8'hxx;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        tick(CPB);
    endtask

    // Line is left at the stop level so a low stop can be held by the caller.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_in = 1'b1;
        tick(3);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_frame();
        int t0;
        clr();
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        tick(2 * CPB);
        total++; if (vld_cnt !== 1) begin bad++; $display("FAIL frame_vld_count: got %0d want 1", vld_cnt); end
        total++; if (capt[0] !== 8'hA5) begin bad++; $display("FAIL frame_capture: got %h want a5", capt[0]); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL frame_data_out: got %h want a5", data_out); end
        total++; if (ferr_cnt !== 0) begin bad++; $display("FAIL frame_no_ferr: got %0d want 0", ferr_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame_busy_low: got %b want 0", busy); end
        total++;
        if ((vld_cyc - t0) < LAT - 1 || (vld_cyc - t0) > LAT + 1) begin
            bad++; $display("FAIL frame_latency: got %0d want %0d+-1", vld_cyc - t0, LAT);
        end
    endtask

    task automatic test_back_to_back();
        clr();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(2 * CPB);
        total++; if (vld_cnt !== 2) begin bad++; $display("FAIL b2b_vld_count: got %0d want 2", vld_cnt); end
        total++; if (capt[0] !== 8'h00) begin bad++; $display("FAIL b2b_first: got %h want 00", capt[0]); end
        total++; if (capt[1] !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h want ff", capt[1]); end
        total++; if (ferr_cnt !== 0) begin bad++; $display("FAIL b2b_no_ferr: got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_frame_err();
        clr();
        send_frame(8'h3C, 1'b0);
        tick(20);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_held: got %b want 1", busy); end
        total++; if (ferr_cnt !== 1) begin bad++; $display("FAIL ferr_pulse_low: got %0d want 1", ferr_cnt); end
        rx_in = 1'b1;
        tick(2 * CPB);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_release: got %b want 0", busy); end
        total++; if (ferr_cnt !== 1) begin bad++; $display("FAIL ferr_pulse_count: got %0d want 1", ferr_cnt); end
        total++; if (vld_cnt !== 0) begin bad++; $display("FAIL ferr_no_valid: got %0d want 0", vld_cnt); end
        total++; if (data_out !== 8'hFF) begin bad++; $display("FAIL ferr_data_kept: got %h want ff", data_out); end
    endtask

    task automatic test_glitch();
        clr();
        rx_in = 1'b0;
        tick(1);
        rx_in = 1'b1;
        tick(3 * CPB);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle: got %b want 0", busy); end
        total++; if (vld_cnt !== 0) begin bad++; $display("FAIL glitch_no_valid: got %0d want 0", vld_cnt); end
        total++; if (ferr_cnt !== 0) begin bad++; $display("FAIL glitch_no_ferr: got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'h5A;
        clr();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx_in = d[4];
        tick(CPB / 2);
        rst_n = 1'b0;
        rx_in = 1'b1;
        #1;
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rstmid_data_out: got %h want 00", data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", data_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_ferr: got %b want 0", frame_err); end
        tick(3);
        rst_n = 1'b1;
        tick(3 * CPB);
        send_frame(8'h81, 1'b1);
        tick(2 * CPB);
        total++; if (vld_cnt !== 1) begin bad++; $display("FAIL rstmid_vld_count: got %0d want 1", vld_cnt); end
        total++; if (capt[0] !== 8'h81) begin bad++; $display("FAIL rstmid_capture: got %h want 81", capt[0]); end
        total++; if (data_out !== 8'h81) begin bad++; $display("FAIL rstmid_data_out_new: got %h want 81", data_out); end
        total++; if (ferr_cnt !== 0) begin bad++; $display("FAIL rstmid_no_ferr: got %0d want 0", ferr_cnt); end
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic send_par_frame(input logic [7:0] d, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(1'b1);
        tick(2 * CPB);
    endtask

    task automatic test_parity();
        clr();
        send_par_frame(8'h07, 1'b1);
        total++; if (vld_cnt !== 1) begin bad++; $display("FAIL par_ok_valid: got %0d want 1", vld_cnt); end
        total++; if (data_out !== 8'h07) begin bad++; $display("FAIL par_ok_data: got %h want 07", data_out); end
        total++; if (perr_cnt !== 0) begin bad++; $display("FAIL par_ok_no_perr: got %0d want 0", perr_cnt); end
        clr();
        send_par_frame(8'h07, 1'b0);
        send_par_frame(8'h06, 1'b1);
        total++; if (perr_cnt !== 2) begin bad++; $display("FAIL par_err_count: got %0d want 2", perr_cnt); end
        total++; if (vld_cnt !== 0) begin bad++; $display("FAIL par_err_no_valid: got %0d want 0", vld_cnt); end
        total++; if (data_out !== 8'h07) begin bad++; $display("FAIL par_err_data_kept: got %h want 07", data_out); end
        total++; if (ferr_cnt !== 0) begin bad++; $display("FAIL par_err_no_ferr: got %0d want 0", ferr_cnt); end
    endtask
`endif

    task automatic test_exclusive();
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL pulse_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        both_cnt = 0;
        vld_cyc  = 0;
        clr();
        test_reset();
        test_frame();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
